// File: rtl/gray_counter_if.sv
// ============================================================================
//  Module   : gray_counter_if
//  Brief    : Control/status bundle for the Gray-code up/down counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             wrap_en;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic             clr_ovf;
    logic [WIDTH-1:0] g;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, wrap_en, load, load_bin, clr_ovf,
        input  g, tc, ovf
    );

    modport slave (
        input  en, up, wrap_en, load, load_bin, clr_ovf,
        output g, tc, ovf
    );
endinterface

`default_nettype wire

// File: rtl/gray_counter.sv
// ============================================================================
//  Module   : gray_counter
//  Brief    : Up/down binary counter with registered Gray output, wrap or
//             saturate at the range limits, and a sticky overflow flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gray_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    gray_counter_if.slave     bus
);
    localparam logic [WIDTH-1:0] c_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_g;
    logic             r_ovf;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_g_nxt;
    logic             w_sat;
    logic             w_ovf_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_sat     = 1'b0;
        if (bus.load) begin
            w_cnt_nxt = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                if (r_cnt != c_MAX)    w_cnt_nxt = r_cnt + c_ONE;
                else if (bus.wrap_en)  w_cnt_nxt = c_ZERO;
                else                   w_sat     = 1'b1;
            end else begin
                if (r_cnt != c_ZERO)   w_cnt_nxt = r_cnt - c_ONE;
                else if (bus.wrap_en)  w_cnt_nxt = c_MAX;
                else                   w_sat     = 1'b1;
            end
        end
    end

    // Gray code is computed from the next count so g lands on the same edge as cnt.
    assign w_g_nxt   = w_cnt_nxt ^ (w_cnt_nxt >> 1);
    // A saturate event on the same edge as clr_ovf leaves the flag set.
    assign w_ovf_nxt = w_sat | (r_ovf & ~bus.clr_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_g   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_g   <= w_g_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign bus.g   = r_g;
    assign bus.ovf = r_ovf;
    assign bus.tc  = bus.up ? (r_cnt == c_MAX) : (r_cnt == c_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_gray_counter.sv
// ============================================================================
//  Module   : tb_gray_counter
//  Brief    : Self-checking bench for gray_counter against an arithmetic model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gray_counter;
    localparam int WIDTH = 4;
    localparam int MAX   = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gray_counter_if #(.WIDTH(WIDTH)) bus ();

    gray_counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int m_cnt;
    bit m_ovf;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int exp_tc();
        return bus.up ? int'(m_cnt == MAX) : int'(m_cnt == 0);
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".g"},   32'(bus.g),   32'(to_gray(m_cnt)));
        check_eq({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
        check_eq({tag, ".tc"},  32'(bus.tc),  32'(exp_tc()));
    endtask

    // Reference: step as signed arithmetic, then either fold modulo 2^WIDTH or refuse.
    task automatic model_edge(output bit stepped);
        int nxt;
        bit sat;
        stepped = 1'b0;
        sat     = 1'b0;
        if (bus.load) begin
            m_cnt = int'(bus.load_bin);
        end else if (bus.en) begin
            nxt = m_cnt + (bus.up ? 1 : -1);
            if (nxt < 0 || nxt > MAX) begin
                if (bus.wrap_en) begin
                    m_cnt   = (nxt + MAX + 1) % (MAX + 1);
                    stepped = 1'b1;
                end else begin
                    sat = 1'b1;
                end
            end else begin
                m_cnt   = nxt;
                stepped = 1'b1;
            end
        end
        if (bus.clr_ovf) m_ovf = 1'b0;
        if (sat)         m_ovf = 1'b1;
    endtask

    task automatic tick(input string tag);
        bit stepped;
        logic [WIDTH-1:0] g_prev;
        g_prev = bus.g;
        model_edge(stepped);
        @(posedge clk);
        #1;
        check_state(tag);
        if (stepped)
            check_eq({tag, ".onebit"}, 32'($countones(g_prev ^ bus.g)), 32'd1);
    endtask

    task automatic set_in(input bit en, input bit up, input bit wrap, input bit ld,
                          input int lb, input bit clr);
        bus.en       = en;
        bus.up       = up;
        bus.wrap_en  = wrap;
        bus.load     = ld;
        bus.load_bin = WIDTH'(lb);
        bus.clr_ovf  = clr;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        #2;
        check_state(tag);
        rst = 1'b0;
    endtask

    int up_seq [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        set_in(0, 1, 1, 0, 0, 0);
        #1;
        do_reset("reset0");
        @(posedge clk);
        #1;

        // Full up-count with wrap
        set_in(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick("upwrap");
            check_eq("upwrap.seq", 32'(bus.g), 32'(up_seq[i]));
        end

        // Down-wrap from zero
        do_reset("reset1");
        set_in(1, 0, 1, 0, 0, 0);
        tick("downwrap");
        check_eq("downwrap.g", 32'(bus.g), 32'd8);

        // Saturate at MAX
        set_in(0, 1, 0, 1, 15, 0);
        tick("load15");
        set_in(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("sat");
        check_eq("sat.g",   32'(bus.g),   32'd8);
        check_eq("sat.ovf", 32'(bus.ovf), 32'd1);
        check_eq("sat.tc",  32'(bus.tc),  32'd1);

        // clr_ovf colliding with a saturate event, then a plain clear
        set_in(1, 1, 0, 0, 0, 1);
        tick("clrcoll");
        check_eq("clrcoll.ovf", 32'(bus.ovf), 32'd1);
        set_in(0, 1, 0, 0, 0, 1);
        tick("clr");
        check_eq("clr.ovf", 32'(bus.ovf), 32'd0);

        // Load beats enable and leaves a set ovf alone
        set_in(1, 1, 0, 0, 0, 0);
        tick("resat");
        set_in(1, 1, 0, 1, 10, 0);
        tick("loadpri");
        check_eq("loadpri.g",   32'(bus.g),   32'd15);
        check_eq("loadpri.ovf", 32'(bus.ovf), 32'd1);

        // Hold with en low regardless of up/wrap_en
        set_in(0, 0, 0, 0, 0, 0);
        tick("hold0");
        set_in(0, 1, 1, 0, 0, 0);
        tick("hold1");

        // Asynchronous reset mid-count with a load pending
        do_reset("reset2");
        set_in(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick("pre_ar");
        check_eq("pre_ar.g", 32'(bus.g), 32'd6);
        set_in(1, 1, 1, 1, 9, 0);
        rst = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        #2;
        check_eq("async.g",   32'(bus.g),   32'd0);
        check_eq("async.ovf", 32'(bus.ovf), 32'd0);
        @(posedge clk);
        #1;
        check_eq("async.hold", 32'(bus.g), 32'd0);
        rst = 1'b0;
        set_in(1, 1, 1, 0, 0, 0);
        tick("postrst");
        check_eq("postrst.g", 32'(bus.g), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom_range(0, 15) == 0), $urandom_range(0, MAX),
                   ($urandom_range(0, 7) == 0));
            tick("rand");
            if ($urandom_range(0, 3) == 0) begin
                bus.up = ~bus.up;
                #1;
                check_eq("rand.tc_dir", 32'(bus.tc), 32'(exp_tc()));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
